// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the arbiter state encoding and the Wishbone idle-bus cycle-type defaults.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wshb_arb_mux.sv
// Combinational request/response steering between two Wishbone masters and one slave.
// Ports: gnt_i selects the owner; m*_ _i master requests; s_*_o slave bus; m*_ack_o/m*_dat_sm_o responses.
module wshb_arb_mux
    import wshb_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 32
) (
    input  logic [1:0]          gnt_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADR_W-1:0]    m0_adr_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [2:0]          m0_cti_i,
    input  logic [1:0]          m0_bte_i,
    input  logic [DATA_W-1:0]   m0_dat_ms_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADR_W-1:0]    m1_adr_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [2:0]          m1_cti_i,
    input  logic [1:0]          m1_bte_i,
    input  logic [DATA_W-1:0]   m1_dat_ms_i,
    input  logic                s_ack_i,
    input  logic [DATA_W-1:0]   s_dat_sm_i,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADR_W-1:0]    s_adr_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [2:0]          s_cti_o,
    output logic [1:0]          s_bte_o,
    output logic [DATA_W-1:0]   s_dat_ms_o,
    output logic                m0_ack_o,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m0_dat_sm_o,
    output logic [DATA_W-1:0]   m1_dat_sm_o
);

    // Read data is broadcast; only the ack qualifies it.
    assign m0_dat_sm_o = s_dat_sm_i;
    assign m1_dat_sm_o = s_dat_sm_i;

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_sel_o    = '0;
        s_cti_o    = WB_CTI_CLASSIC;
        s_bte_o    = WB_BTE_LINEAR;
        s_dat_ms_o = '0;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        unique case (1'b1)
            gnt_i[0]: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_sel_o    = m0_sel_i;
                s_cti_o    = m0_cti_i;
                s_bte_o    = m0_bte_i;
                s_dat_ms_o = m0_dat_ms_i;
                // An ack with no strobe outstanding is spurious.
                m0_ack_o   = s_ack_i & m0_stb_i;
            end
            gnt_i[1]: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_sel_o    = m1_sel_i;
                s_cti_o    = m1_cti_i;
                s_bte_o    = m1_bte_i;
                s_dat_ms_o = m1_dat_ms_i;
                m1_ack_o   = s_ack_i & m1_stb_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Round-robin two-master Wishbone arbiter with a per-tenure beat quantum.
// Ports: m0_*/m1_* master buses, s_* slave bus, gnt one-hot registered grant {m1,m0}.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADR_W   = 32,
    parameter int QUANTUM = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [ADR_W-1:0]    m0_adr,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic [2:0]          m0_cti,
    input  logic [1:0]          m0_bte,
    input  logic [DATA_W-1:0]   m0_dat_ms,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_dat_sm,
    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [ADR_W-1:0]    m1_adr,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic [2:0]          m1_cti,
    input  logic [1:0]          m1_bte,
    input  logic [DATA_W-1:0]   m1_dat_ms,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_dat_sm,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [ADR_W-1:0]    s_adr,
    output logic [DATA_W/8-1:0] s_sel,
    output logic [2:0]          s_cti,
    output logic [1:0]          s_bte,
    output logic [DATA_W-1:0]   s_dat_ms,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_dat_sm,
    output logic [1:0]          gnt
);

    localparam int CNT_W = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
    localparam logic [CNT_W-1:0] QMAX =
        CNT_W'((QUANTUM > 0) ? QUANTUM - 1 : 0);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             beat;

    assign gnt  = {state_q == OWN1, state_q == OWN0};
    assign beat = s_ack & s_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc && m1_cyc)
                    state_d = last_q ? OWN0 : OWN1;
                else if (m0_cyc)
                    state_d = OWN0;
                else if (m1_cyc)
                    state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc) begin
                    // Direct handoff avoids an idle bubble.
                    state_d = m1_cyc ? OWN1 : IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (beat && QUANTUM != 0) begin
                    if (cnt_q == QMAX) begin
                        // Quantum spent: yield only if contended,
                        // otherwise hold at QMAX.
                        if (m1_cyc) begin
                            state_d = OWN1;
                            last_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!m1_cyc) begin
                    state_d = m0_cyc ? OWN0 : IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (beat && QUANTUM != 0) begin
                    if (cnt_q == QMAX) begin
                        if (m0_cyc) begin
                            state_d = OWN0;
                            last_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    wshb_arb_mux #(
        .DATA_W (DATA_W),
        .ADR_W  (ADR_W)
    ) u_mux (
        .gnt_i       (gnt),
        .m0_cyc_i    (m0_cyc),
        .m0_stb_i    (m0_stb),
        .m0_we_i     (m0_we),
        .m0_adr_i    (m0_adr),
        .m0_sel_i    (m0_sel),
        .m0_cti_i    (m0_cti),
        .m0_bte_i    (m0_bte),
        .m0_dat_ms_i (m0_dat_ms),
        .m1_cyc_i    (m1_cyc),
        .m1_stb_i    (m1_stb),
        .m1_we_i     (m1_we),
        .m1_adr_i    (m1_adr),
        .m1_sel_i    (m1_sel),
        .m1_cti_i    (m1_cti),
        .m1_bte_i    (m1_bte),
        .m1_dat_ms_i (m1_dat_ms),
        .s_ack_i     (s_ack),
        .s_dat_sm_i  (s_dat_sm),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_adr_o     (s_adr),
        .s_sel_o     (s_sel),
        .s_cti_o     (s_cti),
        .s_bte_o     (s_bte),
        .s_dat_ms_o  (s_dat_ms),
        .m0_ack_o    (m0_ack),
        .m1_ack_o    (m1_ack),
        .m0_dat_sm_o (m0_dat_sm),
        .m1_dat_sm_o (m1_dat_sm)
    );

endmodule
